// File: rtl/omsp_spm_cmd_sequencer_pkg.sv
// Shared encodings for the SPM command sequencer: command codes, FSM states, key sizing.
package omsp_spm_cmd_sequencer_pkg;

    localparam int unsigned SPM_SECURITY  = 64;
    localparam int unsigned SPM_KEY_WORDS = SPM_SECURITY / 16;

    typedef enum logic [1:0] {
        CMD_PROTECT   = 2'b00,
        CMD_UNPROTECT = 2'b01,
        CMD_VERIFY    = 2'b10,
        CMD_ILLEGAL   = 2'b11
    } spm_cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StCheck,
        StWaitKey,
        StWriteKey,
        StDone,
        StFail
    } spm_state_e;

    function automatic int unsigned key_words(input int unsigned security);
        return security / 16;
    endfunction

endpackage

// File: rtl/omsp_spm_key_serializer.sv
// Holds the derived module key and streams it into the SPM array one 16-bit word per cycle,
// word 0 being the most significant word of the key.
module omsp_spm_key_serializer
    import omsp_spm_cmd_sequencer_pkg::*;
#(
    parameter int unsigned SECURITY     = SPM_SECURITY,
    parameter int unsigned KEY_IDX_SIZE = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic                    i_clear,
    input  logic                    i_active,
    input  logic [SECURITY-1:0]     i_key_data,
    output logic                    o_write_key,
    output logic [15:0]             o_key_in,
    output logic [KEY_IDX_SIZE-1:0] o_key_idx,
    output logic                    o_last
);

    localparam int unsigned KEY_WORDS = key_words(SECURITY);

    logic [SECURITY-1:0]     r_key;
    logic [KEY_IDX_SIZE-1:0] r_cnt;
    logic [15:0]             w_words [KEY_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_key <= '0;
        end else if (i_load) begin
            r_key <= i_key_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || i_load) begin
            r_cnt <= '0;
        end else if (i_active) begin
            r_cnt <= r_cnt + KEY_IDX_SIZE'(1);
        end
    end

    // The external bit numbering counts bit 0 as the MSB, so word 0 sits at the top.
    for (genvar g = 0; g < KEY_WORDS; g++) begin : g_word
        assign w_words[g] = r_key[SECURITY-1-16*g -: 16];
    end

    always_comb begin
        o_write_key = i_active;
        o_key_in    = i_active ? w_words[r_cnt] : '0;
        o_key_idx   = i_active ? r_cnt : '0;
        o_last      = (r_cnt == KEY_IDX_SIZE'(KEY_WORDS - 1));
    end

endmodule

// File: rtl/omsp_spm_cmd_sequencer.sv
// SPM command sequencer: issues protect/unprotect/verify to the SPM array and loads the module key.
// Optional build macro SPM_KEY_TIMEOUT_EN bounds the wait for the crypto unit's key.
module omsp_spm_cmd_sequencer
    import omsp_spm_cmd_sequencer_pkg::*;
#(
    parameter int unsigned SECURITY     = SPM_SECURITY,
    parameter int unsigned KEY_IDX_SIZE = 2,
    parameter int unsigned KEY_TIMEOUT  = 255
) (
    input  logic                    i_mclk,
    input  logic                    i_puc_rst,
    input  logic                    i_cmd_valid,
    input  logic [1:0]              i_cmd_type,
    output logic                    o_cmd_ready,
    input  logic                    i_violation,
    output logic                    o_key_req,
    input  logic                    i_key_valid,
    input  logic [SECURITY-1:0]     i_key_data,
    output logic                    o_update_spm,
    output logic                    o_enable_spm,
    output logic                    o_disable_spm,
    output logic                    o_verify_spm,
    output logic                    o_write_key,
    output logic [15:0]             o_key_in,
    output logic [KEY_IDX_SIZE-1:0] o_key_idx,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_fail
);

    if (SECURITY == 0 || SECURITY % 16 != 0) begin : g_bad_security
        $error("SECURITY must be a nonzero multiple of 16");
    end
    if ((1 << KEY_IDX_SIZE) != SECURITY / 16) begin : g_bad_idx
        $error("2**KEY_IDX_SIZE must equal SECURITY/16");
    end
    if (KEY_TIMEOUT == 0) begin : g_bad_timeout
        $error("KEY_TIMEOUT must be at least 1");
    end

    spm_state_e r_state;
    spm_state_e w_state_nxt;
    spm_cmd_e   r_cmd;
    logic       w_capture;
    logic       w_clear;
    logic       w_last;
    logic       w_tmo_expired;

    always_ff @(posedge i_mclk) begin
        if (i_puc_rst) begin
            r_state <= StIdle;
            r_cmd   <= CMD_PROTECT;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle && i_cmd_valid) begin
                r_cmd <= spm_cmd_e'(i_cmd_type);
            end
        end
    end

`ifdef SPM_KEY_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(KEY_TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo;

    // Held at the limit outside WAIT_KEY, so it is freshly loaded on every entry.
    always_ff @(posedge i_mclk) begin
        if (i_puc_rst) begin
            r_tmo <= '0;
        end else if (r_state != StWaitKey) begin
            r_tmo <= TMO_W'(KEY_TIMEOUT);
        end else if (r_tmo != '0) begin
            r_tmo <= r_tmo - TMO_W'(1);
        end
    end

    assign w_tmo_expired = (r_tmo == '0);
`else
    assign w_tmo_expired = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_cmd_valid) begin
                    w_state_nxt = (spm_cmd_e'(i_cmd_type) == CMD_ILLEGAL) ? StFail : StIssue;
                end
            end
            StIssue: begin
                w_state_nxt = (r_cmd == CMD_UNPROTECT) ? StDone : StCheck;
            end
            StCheck: begin
                if (i_violation) begin
                    w_state_nxt = StFail;
                end else if (r_cmd == CMD_VERIFY) begin
                    w_state_nxt = StDone;
                end else begin
                    w_state_nxt = StWaitKey;
                end
            end
            StWaitKey: begin
                // A key arriving on the expiry cycle still wins over the timeout.
                if (i_key_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StWriteKey;
                end else if (w_tmo_expired) begin
                    w_state_nxt = StFail;
                end
            end
            StWriteKey: begin
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone, StFail: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        w_clear = (w_state_nxt == StDone) || (w_state_nxt == StFail);
    end

    omsp_spm_key_serializer #(
        .SECURITY     (SECURITY),
        .KEY_IDX_SIZE (KEY_IDX_SIZE)
    ) u_ser (
        .i_clk       (i_mclk),
        .i_rst       (i_puc_rst),
        .i_load      (w_capture),
        .i_clear     (w_clear),
        .i_active    (r_state == StWriteKey),
        .i_key_data  (i_key_data),
        .o_write_key (o_write_key),
        .o_key_in    (o_key_in),
        .o_key_idx   (o_key_idx),
        .o_last      (w_last)
    );

    always_comb begin
        o_cmd_ready   = (r_state == StIdle);
        o_busy        = (r_state != StIdle);
        o_update_spm  = (r_state == StIssue) &&
                        (r_cmd == CMD_PROTECT || r_cmd == CMD_UNPROTECT);
        o_enable_spm  = (r_state == StIssue) && (r_cmd == CMD_PROTECT);
        o_disable_spm = (r_state == StIssue) && (r_cmd == CMD_UNPROTECT);
        o_verify_spm  = (r_state == StIssue) && (r_cmd == CMD_VERIFY);
        o_key_req     = (r_state == StWaitKey);
        o_done        = (r_state == StDone);
        o_fail        = (r_state == StFail);
    end

endmodule

// File: doc/omsp_spm_cmd_sequencer.md
Name: omsp_spm_cmd_sequencer

Overview:
Initiator side of the SPM array control interface. It accepts one protect, unprotect or verify command from the execution unit and drives the update/enable/disable/verify strobes. It samples the array's violation response. For protect, it then obtains the derived module key from the crypto unit and streams it into the array 16 bits per cycle through write_key/key_in/key_idx. It sits between the execution unit / crypto unit and omsp_spm_control.

Parameters:
SECURITY, 64, key width in bits; must be a multiple of 16.
KEY_IDX_SIZE, 2, key word index width; 2**KEY_IDX_SIZE == SECURITY/16.
KEY_TIMEOUT, 255, key-wait cycle limit; used only with SPM_KEY_TIMEOUT_EN.

Ports:
mclk  in  1  clock.
puc_rst  in  1  reset, synchronous, active-high.
cmd_valid  in  1  command request.
cmd_type  in  2  00 protect, 01 unprotect, 10 verify, 11 illegal.
cmd_ready  out  1  high only in IDLE.
violation  in  1  array violation response.
key_req  out  1  key derivation request to crypto unit.
key_valid  in  1  key_data valid.
key_data  in  SECURITY  derived key; bit 0 is the MSB, big-endian words.
update_spm  out  1  array update strobe.
enable_spm  out  1  protect qualifier.
disable_spm  out  1  unprotect qualifier.
verify_spm  out  1  verify strobe.
write_key  out  1  key word write strobe.
key_in  out  16  key word.
key_idx  out  KEY_IDX_SIZE  key word index.
busy  out  1  not IDLE.
done  out  1  one-cycle success pulse.
fail  out  1  one-cycle failure pulse.

Behaviour:
- Registered FSM with states IDLE, ISSUE, CHECK, WAIT_KEY, WRITE_KEY, DONE, FAIL. All strobes are decoded from state and registers, so they are glitch-free.
- Reset: state IDLE; all outputs 0 except cmd_ready=1; key register cleared; word counter 0.
- IDLE: if cmd_valid is high, latch cmd_type and go to ISSUE. Type 11 goes directly to FAIL. Without cmd_valid, stay in IDLE.
- ISSUE (1 cycle), by command:
  - protect: update_spm=1, enable_spm=1.
  - unprotect: update_spm=1, disable_spm=1, enable_spm=0.
  - verify: verify_spm=1.
  - Next state: unprotect goes to DONE; protect and verify go to CHECK.
- CHECK (1 cycle): violation is sampled here, the cycle after the strobe.
  - violation=1: go to FAIL.
  - violation=0, verify: go to DONE.
  - violation=0, protect: go to WAIT_KEY.
- WAIT_KEY: key_req=1. When key_valid is seen, capture key_data, clear the counter and go to WRITE_KEY. key_req drops the cycle after capture.
- WRITE_KEY: lasts exactly SECURITY/16 cycles.
  - Each cycle: write_key=1, key_idx=counter, key_in=key_reg[counter*16 +: 16] (word 0 = bits 0..15).
  - The counter increments every cycle. On the last index, go to DONE. The counter does not wrap into a further write.
- DONE / FAIL: pulse done or fail for 1 cycle, then go to IDLE. cmd_ready rises the following cycle.
- Latency (command accepted to done):
  - unprotect: 2 cycles.
  - verify: 3 cycles.
  - protect: 3 + key wait + SECURITY/16 + 1 cycles.
- Ignored or non-interrupting inputs:
  - cmd_valid while busy is ignored; cmd_ready=0, no queueing.
  - violation outside CHECK is ignored by the FSM.
  - key_valid outside WAIT_KEY is ignored.
- Key register: cleared to 0 on entry to DONE or FAIL. Key material never persists past a command.
- Reset mid-operation: immediate return to reset state. No partial strobes follow; write_key=0 on the next cycle.

Optional Feature:
SPM_KEY_TIMEOUT_EN
- Defined: WAIT_KEY runs a down-counter loaded with KEY_TIMEOUT on entry. If it reaches 0 with key_valid still low, go to FAIL with key_req deasserted. key_valid arriving on the expiry cycle wins: capture proceeds.
- Undefined: WAIT_KEY waits indefinitely; no counter logic is synthesised.

Decomposition:
- Shared package/defines:
  - command encodings (CMD_PROTECT=2'b00, CMD_UNPROTECT=2'b01, CMD_VERIFY=2'b10);
  - FSM state encodings;
  - SECURITY and derived KEY_WORDS = SECURITY/16.
- One sub-module, omsp_spm_key_serializer: key register, word counter, key_in/key_idx/write_key generation, done-last-word flag. The FSM stays in omsp_spm_cmd_sequencer.

Test Plan:
- Protect with violation=0 and key_data=64'h0123_4567_89AB_CDEF valid 5 cycles after key_req:
  - key_in sequence 0123, 4567, 89AB, CDEF with key_idx 0..3 on consecutive cycles;
  - done one cycle later; update_spm&enable_spm high exactly one cycle.
- Protect with violation=1 in CHECK: fail pulse; key_req never asserted; write_key never asserted.
- Unprotect: update_spm=1, disable_spm=1, enable_spm=0 for one cycle; done 2 cycles after accept; cmd_valid held during busy yields no second command.
- Verify with violation=0: verify_spm one cycle, then done. Repeat with violation=1: fail. cmd_type=11: fail the cycle after accept, no strobes.
- puc_rst asserted during WRITE_KEY at key_idx=2: next cycle write_key=0, busy=0, cmd_ready=1; next protect starts cleanly from key_idx=0.
- SPM_KEY_TIMEOUT_EN with KEY_TIMEOUT=4 and key_valid held low: fail pulse after timeout and key_req drops. Also key_valid on the expiry cycle: key written, done.
